// File: rtl/general_register_entry_mp_pkg.sv
// Shared definitions for general_register_entry_mp: state encoding, default widths
// and the slot offset helper used to slice packed per-port buses.
package general_register_entry_mp_pkg;

  localparam int DEF_REGNAME_W = 6;
  localparam int DEF_LOGIC_W   = 5;
  localparam int DEF_TAG_W     = 6;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ARCH_REGS = 32;

  typedef enum logic [2:0] {
    INIT_ARCH = 3'd0,
    INIT_FREE = 3'd1,
    FREE_WAIT = 3'd2,
    IDLE      = 3'd3,
    ALLOC     = 3'd4
  } entry_state_e;

  // LSB of slot `slot` in a bus of `width`-bit fields packed from bit 0 upward.
  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/general_register_entry_prio_match.sv
// Finds the lowest-index valid slot whose key equals `key`; reports hit and index.
module general_register_entry_prio_match
  import general_register_entry_mp_pkg::*;
#(
  parameter int N     = 2,
  parameter int KEY_W = 6,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]       valid,
  input  logic [N*KEY_W-1:0] keys,
  input  logic [KEY_W-1:0]   key,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise unassigned paths infer latches.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Scan from the top so the lowest matching slot is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i] && (keys[slot_lsb(i, KEY_W) +: KEY_W] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/general_register_entry_mp.sv
// One physical-register entry of the rename file with parametrised rename/writeback ports.
// Optional writeback-collision flag enabled by GENERAL_REGISTER_ENTRY_WB_CHECK_EN.
module general_register_entry_mp
  import general_register_entry_mp_pkg::*;
#(
  parameter int ENTRY_ID     = 0,
  parameter int REGNAME_W    = DEF_REGNAME_W,
  parameter int LOGIC_W      = DEF_LOGIC_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ARCH_REGS    = DEF_ARCH_REGS,
  parameter int REGIST_PORTS = 2,
  parameter int EXEND_PORTS  = 3
) (
  input  logic                              iCLOCK,
  input  logic                              iRESET_SYNC,
  input  logic                              iFREE_RESTART,
  input  logic [2**TAG_W-1:0]               iCOMMIT_VECTOR,
  input  logic [REGIST_PORTS-1:0]           iREGIST_VALID,
  input  logic [REGIST_PORTS*REGNAME_W-1:0] iREGIST_DESTINATION_REGNAME,
  input  logic [REGIST_PORTS*LOGIC_W-1:0]   iREGIST_LOGIC_DESTINATION,
  input  logic [REGIST_PORTS*TAG_W-1:0]     iREGIST_COMMIT_TAG,
  input  logic [EXEND_PORTS-1:0]            iEXEND_VALID,
  input  logic [EXEND_PORTS*TAG_W-1:0]      iEXEND_COMMIT_TAG,
  input  logic [EXEND_PORTS*DATA_W-1:0]     iEXEND_DATA,
  input  logic                              iFREELIST_REGIST_VALID,
  output logic                              oINFO_FREELIST_REQ,
  output logic                              oINFO_DATA_VALID,
  output logic [DATA_W-1:0]                 oINFO_DATA
`ifdef GENERAL_REGISTER_ENTRY_WB_CHECK_EN
  , output logic                            oERR_WB_COLLISION
`endif
);

  localparam int RP_IDX_W = idx_width(REGIST_PORTS);
  localparam int EP_IDX_W = idx_width(EXEND_PORTS);
  localparam logic [REGNAME_W-1:0] ENTRY_NAME  = REGNAME_W'(ENTRY_ID);
  localparam logic [LOGIC_W-1:0]   ENTRY_LOGIC = LOGIC_W'(ENTRY_ID);
  localparam bit ARCH_MAPPED = (ENTRY_ID < ARCH_REGS);

  typedef struct packed {
    logic               data_valid;
    logic [DATA_W-1:0]  data;
    logic [LOGIC_W-1:0] logic_dest;
    logic [TAG_W-1:0]   tag;
    logic               commit_valid;
    logic               after_valid;
    logic [TAG_W-1:0]   after_tag;
    logic               after_commit;
  } fields_t;

  entry_state_e state;
  logic         req;
  fields_t      f;

  // Allocation: lowest rename slot naming this physical register.
  logic                alloc_hit;
  logic [RP_IDX_W-1:0] alloc_idx;
  logic [LOGIC_W-1:0]  alloc_logic;
  logic [TAG_W-1:0]    alloc_tag;

  general_register_entry_prio_match #(
    .N(REGIST_PORTS), .KEY_W(REGNAME_W), .IDX_W(RP_IDX_W)
  ) u_alloc_match (
    .valid(iREGIST_VALID),
    .keys (iREGIST_DESTINATION_REGNAME),
    .key  (ENTRY_NAME),
    .hit  (alloc_hit),
    .idx  (alloc_idx)
  );

  assign alloc_logic = iREGIST_LOGIC_DESTINATION[slot_lsb(int'(alloc_idx), LOGIC_W) +: LOGIC_W];
  assign alloc_tag   = iREGIST_COMMIT_TAG[slot_lsb(int'(alloc_idx), TAG_W) +: TAG_W];

  // Next-writer search; the key and slot mask depend on the state so one matcher
  // serves the architectural remap, same-cycle successors and later successors.
  logic [REGIST_PORTS-1:0] after_mask;
  logic [LOGIC_W-1:0]      after_key;
  logic                    after_hit;
  logic [RP_IDX_W-1:0]     after_idx;
  logic [TAG_W-1:0]        after_new_tag;

  always_comb begin
    after_key  = f.logic_dest;
    after_mask = iREGIST_VALID;
    if (state == INIT_ARCH) begin
      after_key = ENTRY_LOGIC;
    end else if (state == IDLE) begin
      after_key = alloc_logic;
      for (int i = 0; i < REGIST_PORTS; i++) begin
        if (i <= int'(alloc_idx)) after_mask[i] = 1'b0;
      end
    end
  end

  general_register_entry_prio_match #(
    .N(REGIST_PORTS), .KEY_W(LOGIC_W), .IDX_W(RP_IDX_W)
  ) u_after_match (
    .valid(after_mask),
    .keys (iREGIST_LOGIC_DESTINATION),
    .key  (after_key),
    .hit  (after_hit),
    .idx  (after_idx)
  );

  assign after_new_tag = iREGIST_COMMIT_TAG[slot_lsb(int'(after_idx), TAG_W) +: TAG_W];

  // Writeback: lowest EXEND port carrying this entry's tag.
  logic                wb_hit;
  logic [EP_IDX_W-1:0] wb_idx;
  logic [DATA_W-1:0]   wb_data;

  general_register_entry_prio_match #(
    .N(EXEND_PORTS), .KEY_W(TAG_W), .IDX_W(EP_IDX_W)
  ) u_wb_match (
    .valid(iEXEND_VALID),
    .keys (iEXEND_COMMIT_TAG),
    .key  (f.tag),
    .hit  (wb_hit),
    .idx  (wb_idx)
  );

  assign wb_data = iEXEND_DATA[slot_lsb(int'(wb_idx), DATA_W) +: DATA_W];

  // NOTE: sequential state is written only with non-blocking assignments so every
  // check below sees the values held before this edge.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state <= INIT_ARCH;
      req   <= 1'b0;
      f     <= '0;
    end else if (iFREE_RESTART) begin
      case (state)
        INIT_ARCH: f <= '0;
        ALLOC: begin
          if (!f.commit_valid) begin
            state <= FREE_WAIT;
            req   <= 1'b1;
            f     <= '0;
          end else if (!f.after_commit) begin
            // Committed value survives; only the speculative successor is dropped.
            f.after_valid <= 1'b0;
            f.after_tag   <= '0;
          end
        end
        default: begin
          state <= FREE_WAIT;
          req   <= 1'b1;
          f     <= '0;
        end
      endcase
    end else begin
      case (state)
        INIT_ARCH: begin
          if (!ARCH_MAPPED || after_hit) begin
            state        <= INIT_FREE;
            req          <= 1'b1;
            f.data_valid <= 1'b0;
          end else begin
            f.data_valid <= 1'b1;
          end
        end
        INIT_FREE, FREE_WAIT: begin
          f.data_valid <= 1'b0;
          if (iFREELIST_REGIST_VALID) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        IDLE: begin
          if (alloc_hit) begin
            state          <= ALLOC;
            f.logic_dest   <= alloc_logic;
            f.tag          <= alloc_tag;
            f.data_valid   <= 1'b0;
            f.commit_valid <= 1'b0;
            f.after_valid  <= after_hit;
            f.after_tag    <= after_hit ? after_new_tag : '0;
            f.after_commit <= 1'b0;
          end
        end
        ALLOC: begin
          if (f.data_valid && f.commit_valid && f.after_valid && f.after_commit) begin
            state <= FREE_WAIT;
            req   <= 1'b1;
          end else begin
            if (!f.after_valid && after_hit) begin
              f.after_valid <= 1'b1;
              f.after_tag   <= after_new_tag;
            end
            if (f.after_valid && iCOMMIT_VECTOR[f.after_tag]) f.after_commit <= 1'b1;
            if (!f.data_valid && wb_hit) begin
              f.data_valid <= 1'b1;
              f.data       <= wb_data;
            end
            if (iCOMMIT_VECTOR[f.tag]) f.commit_valid <= 1'b1;
          end
        end
        default: state <= INIT_ARCH;
      endcase
    end
  end

  assign oINFO_FREELIST_REQ = req && !iFREE_RESTART;
  assign oINFO_DATA_VALID   = f.data_valid && !f.after_commit;
  assign oINFO_DATA         = f.data;

`ifdef GENERAL_REGISTER_ENTRY_WB_CHECK_EN
  logic wb_seen;
  logic wb_multi;

  always_comb begin
    wb_seen  = 1'b0;
    wb_multi = 1'b0;
    for (int i = 0; i < EXEND_PORTS; i++) begin
      if (iEXEND_VALID[i] && (iEXEND_COMMIT_TAG[slot_lsb(i, TAG_W) +: TAG_W] == f.tag)) begin
        if (wb_seen) wb_multi = 1'b1;
        wb_seen = 1'b1;
      end
    end
  end

  // Sticky until reset; a restart does not clear a recorded collision.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oERR_WB_COLLISION <= 1'b0;
    end else if ((state == ALLOC) && (wb_multi || (wb_hit && f.data_valid))) begin
      oERR_WB_COLLISION <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/general_register_entry_mp.md
Name: general_register_entry_mp

Overview:
- One physical-register entry of the scheduler's rename file; generalised successor of the fixed 2-regist/3-writeback entry.
- Tracks per entry: allocation, producer writeback, own commit, and commit of the next writer of the same logical register.
- Requests return to the free list when the entry is dead. Rolls back on iFREE_RESTART.
- Adds parametrised regist/writeback port counts and tag/data widths, with fixed index-priority rules.

Parameters:
ENTRY_ID, 0, physical register number of this entry; ENTRY_ID < ARCH_REGS means the entry holds an initial architectural mapping
REGNAME_W, 6, physical register name width
LOGIC_W, 5, logical register width
TAG_W, 6, commit tag width; commit vector is 2**TAG_W bits
DATA_W, 32, data width
ARCH_REGS, 32, count of initially mapped architectural registers
REGIST_PORTS, 2, rename ports per cycle; lower index is older
EXEND_PORTS, 3, writeback ports; lower index has priority

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  synchronous active-high reset
iFREE_RESTART  in  1  rollback pulse
iCOMMIT_VECTOR  in  2**TAG_W  one bit per committing tag this cycle
iREGIST_VALID  in  REGIST_PORTS  rename slot valid
iREGIST_DESTINATION_REGNAME  in  REGIST_PORTS*REGNAME_W  allocated physical name, slot p at [p*REGNAME_W +: REGNAME_W]
iREGIST_LOGIC_DESTINATION  in  REGIST_PORTS*LOGIC_W  logical destination
iREGIST_COMMIT_TAG  in  REGIST_PORTS*TAG_W  commit tag
iEXEND_VALID  in  EXEND_PORTS  writeback valid
iEXEND_COMMIT_TAG  in  EXEND_PORTS*TAG_W  writeback tag
iEXEND_DATA  in  EXEND_PORTS*DATA_W  writeback data
iFREELIST_REGIST_VALID  in  1  free list accepted this entry
oINFO_FREELIST_REQ  out  1  return request
oINFO_DATA_VALID  out  1  data readable
oINFO_DATA  out  DATA_W  data

Behaviour:
- States: INIT_ARCH=0, INIT_FREE=1, FREE_WAIT=2, IDLE=3, ALLOC=4. All internal registers reset to 0, state to INIT_ARCH.
- Output reset values: oINFO_FREELIST_REQ=0, oINFO_DATA_VALID=0, oINFO_DATA=0.
- INIT_ARCH, case ENTRY_ID<ARCH_REGS:
  - Any valid slot with logic dest == ENTRY_ID[LOGIC_W-1:0] -> INIT_FREE, req=1, data_valid=0.
  - Otherwise stay in INIT_ARCH, data_valid=1 (value 0).
- INIT_ARCH, case ENTRY_ID>=ARCH_REGS: -> INIT_FREE, req=1.
- INIT_FREE and FREE_WAIT:
  - Hold req=1 and data_valid=0 until iFREELIST_REGIST_VALID.
  - On iFREELIST_REGIST_VALID -> IDLE, req=0.
- IDLE:
  - Allocation slot p = lowest valid slot with regname==ENTRY_ID -> ALLOC.
  - On entry to ALLOC: capture logic dest and tag; clear data_valid, commit_valid, after_valid, after_commit.
  - Also on entry: if some valid slot q>p has the same logic dest, set after_valid=1 and after_tag = tag of the lowest such q.
- ALLOC, tracking (each check is independent in the same cycle):
  - If !after_valid: the lowest valid slot with a logic-dest match sets the after tag.
  - If after_valid && COMMIT_VECTOR[after_tag]: after_commit=1.
  - If !data_valid: the lowest-index EXEND port with a tag match writes data; data_valid=1.
  - If COMMIT_VECTOR[tag]: commit_valid=1.
- ALLOC, free: when data_valid && commit_valid && after_valid && after_commit are all 1, go to FREE_WAIT next cycle with req=1. Tracking is frozen in that cycle.
- iFREE_RESTART has priority over normal operation:
  - INIT_ARCH: cleared and stays in INIT_ARCH.
  - INIT_FREE, FREE_WAIT, IDLE: -> FREE_WAIT, req=1, all fields cleared.
  - ALLOC && !commit_valid: -> FREE_WAIT, req=1, cleared.
  - ALLOC && commit_valid && !after_commit: clear after_valid and after_tag, stay in ALLOC.
  - ALLOC && after_commit: unchanged.
- Outputs:
  - oINFO_FREELIST_REQ = req && !iFREE_RESTART.
  - oINFO_DATA_VALID = data_valid && !after_commit.
  - oINFO_DATA = data register.
- Writeback latency: 1 cycle to oINFO_DATA_VALID.
- iRESET_SYNC overrides iFREE_RESTART in any state, including mid-ALLOC.

Optional Feature:
- Macro GENERAL_REGISTER_ENTRY_WB_CHECK_EN.
- Defined: adds output oERR_WB_COLLISION (1 bit), sticky, cleared only by iRESET_SYNC. It sets when, in ALLOC, either:
  - more than one EXEND port matches the tag in one cycle, or
  - a tag match arrives while data_valid=1.
- Not defined: port absent, no check logic, behaviour otherwise identical.

Decomposition:
- Shared package: state encoding constants (INIT_ARCH..ALLOC), default widths, and the slot-extract helper function.
- One natural sub-module, general_register_entry_prio_match. It finds the lowest-index valid slot matching a key and returns hit/index. It is instanced for allocation, after-tag detection and writeback selection.

Test Plan:
- ENTRY_ID=3, reset released, no regist -> data_valid=1, data=0 from cycle 1; then slot0 logic=3 -> req=1 next cycle.
- ENTRY_ID=40: reset -> req=1; FREELIST_VALID -> IDLE; slot1 regname=40 tag=5 logic=7 with slot0 valid -> ALLOC; EXEND port2 tag=5 data=0xDEADBEEF -> data_valid=1 next cycle.
- Allocation on slot0 logic=7 tag=9 and slot1 logic=7 tag=10 -> after_tag=10. Commit bits 9 then 10, after writeback -> data_valid drops with bit 10, req=1 one cycle later.
- EXEND ports 0 and 1 both tag=5, data 0x11/0x22 -> data=0x11. With the macro defined, oERR_WB_COLLISION=1.
- Restart cases from ALLOC: uncommitted -> FREE_WAIT with req=1, masked during the restart cycle; committed with after_valid set and after_commit=0 -> after-tracking cleared, data stays valid.
- iRESET_SYNC asserted mid-ALLOC together with iFREE_RESTART -> INIT_ARCH, all outputs 0.
